// File: rtl/code_word_assembler_pkg.sv
// ============================================================================
// Module : code_word_assembler_pkg
// Brief  : Shared state encoding and word constants for the code word assembler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package code_word_assembler_pkg;

    localparam int WORD_W = 4;
    localparam logic [WORD_W-1:0] BCD_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic logic word_rejected(input logic [WORD_W-1:0] word,
                                           input logic              bcd_en);
        return bcd_en && (word > BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/code_word_assembler_gap_timer.sv
// ============================================================================
// Module : code_word_assembler_gap_timer
// Brief  : Idle-cycle counter; o_expire flags the edge on which it reaches TIMEOUT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module code_word_assembler_gap_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Expire on the edge that would make the count equal TIMEOUT.
    assign o_expire = i_en && (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/code_word_assembler.sv
// ============================================================================
// Module : code_word_assembler
// Brief  : Serial MSB-first 4-bit word assembler with gap timeout and BCD reject.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module code_word_assembler
    import code_word_assembler_pkg::*;
#(
    parameter int TIMEOUT   = 15,
    parameter int BCD_CHECK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic       A1,
    output logic       B1,
    output logic       C1,
    output logic       D1,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       err,
    output logic [7:0] word_cnt
);

    localparam int   c_GAP_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic c_BCD_EN = (BCD_CHECK != 0);

    logic [1:0]        r_state;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_word;
    logic [2:0]        r_bitcnt;
    logic              r_valid;
    logic              r_err;
    logic [7:0]        r_cnt;

    logic              w_accept;
    logic              w_last_bit;
    logic              w_expire;
    logic              w_gap_clr;
    logic              w_gap_en;
    logic [WORD_W-1:0] w_next_word;

    assign bit_ready   = (r_state != ST_HOLD);
    assign w_accept    = bit_valid && bit_ready;
    assign w_next_word = {r_shift[WORD_W-2:0], bit_in};
    assign w_last_bit  = (r_bitcnt == 3'(WORD_W - 1));

    assign w_gap_en    = (r_state == ST_SHIFT) && !w_accept;
    assign w_gap_clr   = (r_state != ST_SHIFT) || w_accept;

    code_word_assembler_gap_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (c_GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_gap_clr),
        .i_en     (w_gap_en),
        .o_expire (w_expire)
    );

    // Bits enter at the LSB; after four shifts the first bit sits in the MSB (A1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_word   <= '0;
            r_bitcnt <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift  <= {{(WORD_W-1){1'b0}}, bit_in};
                        r_bitcnt <= 3'd1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_accept) begin
                        r_shift <= w_next_word;
                        if (w_last_bit) begin
                            r_bitcnt <= '0;
                            if (word_rejected(w_next_word, c_BCD_EN)) begin
                                r_err   <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_word  <= w_next_word;
                                r_valid <= 1'b1;
                                r_state <= ST_HOLD;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else if (w_expire) begin
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (r_valid && word_ready) begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign {A1, B1, C1, D1} = r_word;
    assign word_valid       = r_valid;
    assign err              = r_err;
    assign word_cnt         = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_code_word_assembler.sv
// ============================================================================
// Module : tb_code_word_assembler
// Brief  : Drives BCD-checking and non-checking assemblers against a queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_code_word_assembler;

    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;
    logic bit_in;
    logic bit_valid;
    logic word_ready;

    logic       rdy   [2];
    logic [3:0] dword [2];
    logic       vld   [2];
    logic       e     [2];
    logic [7:0] cnt   [2];

    logic A0, B0, C0, D0, A1x, B1x, C1x, D1x;

    code_word_assembler #(.TIMEOUT(TIMEOUT), .BCD_CHECK(1)) u_dut_bcd (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (rdy[0]),
        .A1         (A0),
        .B1         (B0),
        .C1         (C0),
        .D1         (D0),
        .word_valid (vld[0]),
        .word_ready (word_ready),
        .err        (e[0]),
        .word_cnt   (cnt[0])
    );

    code_word_assembler #(.TIMEOUT(TIMEOUT), .BCD_CHECK(0)) u_dut_any (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (rdy[1]),
        .A1         (A1x),
        .B1         (B1x),
        .C1         (C1x),
        .D1         (D1x),
        .word_valid (vld[1]),
        .word_ready (word_ready),
        .err        (e[1]),
        .word_cnt   (cnt[1])
    );

    assign dword[0] = {A0, B0, C0, D0};
    assign dword[1] = {A1x, B1x, C1x, D1x};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a list of collected bits, an idle-cycle tally and a "held" flag.
    int m_bits  [2][$];
    int m_idle  [2];
    int m_hold  [2];
    int m_out   [2];
    int m_cnt   [2];
    int m_err   [2];
    int m_bcd   [2] = '{1, 0};

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_bits[i].delete();
                m_idle[i] = 0; m_hold[i] = 0; m_out[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
            end else begin
                m_err[i] = 0;
                if (m_hold[i] != 0) begin
                    if (word_ready) begin
                        m_cnt[i]  = (m_cnt[i] + 1) % 256;
                        m_hold[i] = 0;
                    end
                end else if (bit_valid) begin
                    m_bits[i].push_back(int'(bit_in));
                    m_idle[i] = 0;
                    if (m_bits[i].size() == 4) begin
                        int v;
                        v = m_bits[i][0]*8 + m_bits[i][1]*4 + m_bits[i][2]*2 + m_bits[i][3];
                        m_bits[i].delete();
                        if (m_bcd[i] != 0 && v > 9) begin
                            m_err[i] = 1;
                        end else begin
                            m_out[i]  = v;
                            m_hold[i] = 1;
                        end
                    end
                end else if (m_bits[i].size() > 0) begin
                    m_idle[i]++;
                    if (m_idle[i] == TIMEOUT) begin
                        m_err[i]  = 1;
                        m_idle[i] = 0;
                        m_bits[i].delete();
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d_word", i),  32'(dword[i]), 32'(m_out[i]));
            check($sformatf("i%0d_valid", i), 32'(vld[i]),   32'(m_hold[i]));
            check($sformatf("i%0d_err", i),   32'(e[i]),     32'(m_err[i]));
            check($sformatf("i%0d_cnt", i),   32'(cnt[i]),   32'(m_cnt[i]));
            check($sformatf("i%0d_ready", i), 32'(rdy[i]),   32'(m_hold[i] == 0));
        end
    endtask

    task automatic cycle(input logic r, input logic bv, input logic b, input logic wr);
        rst = r; bit_valid = bv; bit_in = b; word_ready = wr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [3:0] w, input logic wr);
        for (int k = 3; k >= 0; k--) begin
            cycle(1'b0, 1'b1, w[k], wr);
        end
    endtask

    initial begin
        logic [3:0] v;
        int         errs;
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_word", 32'(dword[0]), 32'd0);
        check("rst_ready", 32'(rdy[0]), 32'd1);

        // Scenario 1: 0111 delivered with word_ready held high
        send_word(4'b0111, 1'b1);
        check("s1_word", 32'(dword[0]), 32'd7);
        check("s1_valid", 32'(vld[0]), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("s1_drop", 32'(vld[0]), 32'd0);
        check("s1_cnt", 32'(cnt[0]), 32'd1);

        // Scenario 2: 0101 held while downstream stalls, bits offered meanwhile
        send_word(4'b0101, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            check("s2_stable", 32'(dword[0]), 32'd5);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("s2_cnt", 32'(cnt[0]), 32'd2);

        // Scenario 3: timeout after two bits, then 1001
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        errs = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            errs += int'(e[0]);
        end
        check("s3_errpulses", 32'(errs), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_errclear", 32'(e[0]), 32'd0);
        send_word(4'b1001, 1'b0);
        check("s3_word", 32'(dword[0]), 32'd9);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Scenario 4: 1100 rejected by the BCD instance, delivered by the other
        send_word(4'b1100, 1'b0);
        check("s4_err_bcd", 32'(e[0]), 32'd1);
        check("s4_valid_bcd", 32'(vld[0]), 32'd0);
        check("s4_word_any", 32'(dword[1]), 32'd12);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Scenario 5: reset mid-shift and mid-hold
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'(k & 1), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        send_word(4'b0011, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("s5_err", 32'(e[0]), 32'd0);
        check("s5_cnt", 32'(cnt[0]), 32'd0);

        // Scenario 6: 256 deliveries wrap the counter; bit offered during handshake
        for (int n = 0; n < 256; n++) begin
            v = 4'($urandom_range(0, 9));
            send_word(v, 1'b1);
            check("s6_deliv", 32'(dword[0]), 32'(v));
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        end
        check("s6_wrap0", 32'(cnt[0]), 32'd0);
        check("s6_wrap1", 32'(cnt[1]), 32'd0);

        // Random traffic alternating dense and sparse bit offers
        for (int n = 0; n < 3000; n++) begin
            int dense;
            dense = ((n / 300) % 2 == 0) ? 1 : 0;
            cycle(1'($urandom_range(0, 199) == 0),
                  1'(dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
